// File: rtl/lsu_axil_sram_slave_if.sv
// AXI-lite-style read/write channel bundle between the LSU (master) and the SRAM slave.
interface lsu_axil_sram_slave_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [31:0] wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_axil_sram_slave.sv
// Word-array memory slave for the LSU with independent read and write channels, one outstanding
// transaction each, fixed access latency, byte-offset alignment and out-of-range error responses.
// Optional RAND_DELAY_EN: an 8-bit LFSR adds 0..7 extra latency cycles per access and randomly
// withholds arready/awready while idle, to stress upstream stall handling.
module lsu_axil_sram_slave #(
  parameter logic [31:0] Base      = 32'h8000_0000,
  parameter int unsigned Depth     = 65536,
  parameter int unsigned RdLatency = 2,
  parameter int unsigned WrLatency = 2
) (
  input logic                  clk,
  input logic                  rst,
  lsu_axil_sram_slave_if.slave bus
);
  localparam int unsigned IdxW = $clog2(Depth);

  typedef enum logic [1:0] {RdIdle, RdWait, RdResp} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrData, WrWait, WrResp} wr_state_e;

  logic [31:0] mem_q [Depth];

  rd_state_e   rd_st_q;
  logic [31:0] rd_addr_q;
  logic [4:0]  rd_cnt_q;
  logic        arready_q, rvalid_q, rresp_q;
  logic [31:0] rdata_q;

  wr_state_e   wr_st_q;
  logic [31:0] wr_addr_q;
  logic [4:0]  wr_cnt_q;
  logic        awready_q, wready_q, bvalid_q, bresp_q;

  logic [4:0]  lat_extra;
  logic        idle_ready;

`ifdef RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR driving the random delay and stall injection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lat_extra  = {2'b00, lfsr_q[2:0]};
  assign idle_ready = lfsr_q[3];
`else
  assign lat_extra  = 5'd0;
  assign idle_ready = 1'b1;
`endif

  // Address decode; offset is taken from the raw address since Base is word aligned.
  logic [31:0]     rd_diff, wr_diff;
  logic [IdxW-1:0] rd_idx, wr_idx;
  logic            rd_err, wr_err;

  assign rd_diff = rd_addr_q - Base;
  assign wr_diff = wr_addr_q - Base;
  assign rd_idx  = rd_diff[IdxW+1:2];
  assign wr_idx  = wr_diff[IdxW+1:2];
  assign rd_err  = (rd_addr_q < Base) || ((rd_diff >> 2) >= Depth);
  assign wr_err  = (wr_addr_q < Base) || ((wr_diff >> 2) >= Depth);

  // Write merge: strobe and data are shifted up by the byte offset; bits above 31 are lost.
  logic [31:0] wr_mask, wr_bits;
  logic        w_commit;

  assign wr_mask  = bus.wstrb << {wr_addr_q[1:0], 3'b000};
  assign wr_bits  = (bus.wdata & bus.wstrb) << {wr_addr_q[1:0], 3'b000};
  assign w_commit = (wr_st_q == WrData) && bus.wvalid && wready_q && !wr_err;

  // Memory array: not reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | wr_bits;
    end
  end

  // Read channel FSM; the sample sees the array before any same-edge write commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_st_q   <= RdIdle;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (rd_st_q)
        RdIdle: begin
          if (bus.arvalid && arready_q) begin
            rd_addr_q <= bus.araddr;
            rd_cnt_q  <= 5'(RdLatency) + lat_extra;
            arready_q <= 1'b0;
            rd_st_q   <= RdWait;
          end else begin
            arready_q <= idle_ready;
          end
        end
        RdWait: begin
          if (rd_cnt_q == '0) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_err;
            rdata_q  <= rd_err ? 32'h0 : (mem_q[rd_idx] >> {rd_addr_q[1:0], 3'b000});
            rd_st_q  <= RdResp;
          end else begin
            rd_cnt_q <= rd_cnt_q - 5'd1;
          end
        end
        RdResp: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= idle_ready;
            rd_st_q   <= RdIdle;
          end
        end
        default: rd_st_q <= RdIdle;
      endcase
    end
  end

  // Write channel FSM; W is only accepted after the AW handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_st_q   <= WrIdle;
      wr_addr_q <= '0;
      wr_cnt_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
    end else begin
      unique case (wr_st_q)
        WrIdle: begin
          if (bus.awvalid && awready_q) begin
            wr_addr_q <= bus.awaddr;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wr_st_q   <= WrData;
          end else begin
            awready_q <= idle_ready;
          end
        end
        WrData: begin
          if (bus.wvalid && wready_q) begin
            wready_q <= 1'b0;
            wr_cnt_q <= 5'(WrLatency) + lat_extra;
            wr_st_q  <= WrWait;
          end
        end
        WrWait: begin
          if (wr_cnt_q == '0) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err;
            wr_st_q  <= WrResp;
          end else begin
            wr_cnt_q <= wr_cnt_q - 5'd1;
          end
        end
        WrResp: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= idle_ready;
            wr_st_q   <= WrIdle;
          end
        end
        default: wr_st_q <= WrIdle;
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_lsu_axil_sram_slave.sv
// Bench for lsu_axil_sram_slave: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (sparse memory plus due-cycle timestamps).
module tb_lsu_axil_sram_slave;
  localparam logic [31:0] Base   = 32'h8000_0000;
  localparam int unsigned Depth  = 65536;
  localparam int unsigned RdLat  = 2;
  localparam int unsigned WrLat  = 2;
  localparam int          Tmo    = 60;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  lsu_axil_sram_slave_if bus ();

  lsu_axil_sram_slave #(
    .Base      (Base),
    .Depth     (Depth),
    .RdLatency (RdLat),
    .WrLatency (WrLat)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: handshake timed out at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [int unsigned];
  longint      cyc;
  bit          m_arready, m_rvalid, m_rresp, m_rknown, m_rpend;
  logic [31:0] m_rdata, m_raddr;
  longint      m_rdue;
  bit          m_awready, m_wready, m_bvalid, m_bresp, m_wpend;
  logic [31:0] m_waddr;
  longint      m_bdue;

  function automatic bit dec_err(input logic [31:0] a);
    return (a < Base) || (((a - Base) / 4) >= Depth);
  endfunction

  function automatic int unsigned dec_idx(input logic [31:0] a);
    return int'((a - Base) / 4);
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int unsigned i;
    int          sh;
    logic [31:0] old, mask;
    if (!rst) begin
      m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rknown = 0; m_rpend = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_wpend = 0;
      m_rdata = '0;
    end else begin
      ar_hs = m_arready && bus.arvalid;
      r_hs  = m_rvalid && bus.rready;
      aw_hs = m_awready && bus.awvalid;
      w_hs  = m_wready && bus.wvalid;
      b_hs  = m_bvalid && bus.bready;
      cyc++;
      // read data is taken from memory as it stood before this edge's write
      if (m_rpend && cyc == m_rdue) begin
        m_rpend  = 0;
        m_rvalid = 1;
        m_rresp  = dec_err(m_raddr);
        if (m_rresp) begin
          m_rdata = 32'h0; m_rknown = 1;
        end else begin
          i = dec_idx(m_raddr);
          m_rknown = mmem.exists(i);
          m_rdata  = m_rknown ? (mmem[i] >> (8 * m_raddr[1:0])) : 32'h0;
        end
      end
      if (r_hs) m_rvalid = 0;
      if (ar_hs) begin
        m_rpend = 1; m_raddr = bus.araddr; m_rdue = cyc + 1 + RdLat;
      end
      m_arready = !(m_rpend || m_rvalid);

      if (m_wpend && cyc == m_bdue) begin
        m_wpend = 0; m_bvalid = 1; m_bresp = dec_err(m_waddr);
      end
      if (b_hs) m_bvalid = 0;
      if (w_hs) begin
        if (!dec_err(m_waddr)) begin
          i    = dec_idx(m_waddr);
          sh   = 8 * m_waddr[1:0];
          old  = mmem.exists(i) ? mmem[i] : 32'h0;
          mask = bus.wstrb << sh;
          mmem[i] = (old & ~mask) | ((bus.wdata & bus.wstrb) << sh);
        end
        m_wready = 0; m_wpend = 1; m_bdue = cyc + 1 + WrLat;
      end
      if (aw_hs) begin
        m_waddr = bus.awaddr; m_wready = 1;
      end
      m_awready = !(m_wready || m_wpend || m_bvalid);
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("cmp arready", bus.arready, m_arready);
    check("cmp rvalid", bus.rvalid, m_rvalid);
    check("cmp awready", bus.awready, m_awready);
    check("cmp wready", bus.wready, m_wready);
    check("cmp bvalid", bus.bvalid, m_bvalid);
    if (m_rvalid) begin
      check("cmp rresp", bus.rresp, m_rresp);
      if (m_rknown) check("cmp rdata", bus.rdata, m_rdata);
    end
    if (m_bvalid) check("cmp bresp", bus.bresp, m_bresp);
  end

  // ---------------- directed helpers (start and end at posedge + 1) ----------------
  task automatic do_ar(input logic [31:0] a);
    bus.arvalid = 1'b1; bus.araddr = a;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (bus.arready) begin
        @(posedge clk); #1; bus.arvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    tmo("ar handshake");
  endtask

  task automatic do_aw(input logic [31:0] a);
    bus.awvalid = 1'b1; bus.awaddr = a;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (bus.awready) begin
        @(posedge clk); #1; bus.awvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    tmo("aw handshake");
  endtask

  task automatic do_w(input logic [31:0] d, input logic [31:0] s);
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (bus.wready) begin
        @(posedge clk); #1; bus.wvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    tmo("w handshake");
  endtask

  task automatic wait_r(input logic [31:0] ed, input logic er, input int elat, input int stall,
                        input string nm);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1; lat++;
    end
    if (!seen) begin
      tmo({nm, " rvalid"});
      return;
    end
    if (elat >= 0) check({nm, " latency"}, lat, elat);
    check({nm, " rdata"}, bus.rdata, ed);
    check({nm, " rresp"}, bus.rresp, er);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, " stall rvalid"}, bus.rvalid, 1'b1);
      check({nm, " stall rdata"}, bus.rdata, ed);
      check({nm, " stall arready"}, bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1; bus.rready = 1'b0;
  endtask

  task automatic wait_b(input logic er, input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (bus.bvalid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      tmo({nm, " bvalid"});
      return;
    end
    check({nm, " bresp"}, bus.bresp, er);
    bus.bready = 1'b1;
    @(posedge clk); #1; bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [31:0] s,
                          input logic er, input string nm);
    do_aw(a);
    do_w(d, s);
    wait_b(er, nm);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic er,
                         input string nm);
    do_ar(a);
    wait_r(ed, er, 1 + RdLat, 0, nm);
  endtask

  function automatic logic [31:0] pool_addr(input int k);
    int unsigned idx;
    idx = (k < 8) ? k : (Depth - 10 + k);
    return Base + 4 * idx;
  endfunction

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    case (r)
      10:      return Base - 32'd4;
      11:      return Base + 4 * Depth;
      12:      return 32'h0;
      13:      return 32'hFFFF_FFFC;
      14, 15:  return pool_addr(int'($urandom_range(0, 9)));
      default: return pool_addr(int'(r)) + $urandom_range(0, 3);
    endcase
  endfunction

  function automatic logic [31:0] pick_strb();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_00FF;
      1:       return 32'h0000_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset: outputs all zero while held, ready one edge after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset arready", bus.arready, 1'b0);
    check("reset awready", bus.awready, 1'b0);
    check("reset wready", bus.wready, 1'b0);
    check("reset rvalid", bus.rvalid, 1'b0);
    check("reset bvalid", bus.bvalid, 1'b0);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset rresp", bus.rresp, 1'b0);
    check("reset bresp", bus.bresp, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("release arready before edge", bus.arready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("release arready", bus.arready, 1'b1);
    check("release awready", bus.awready, 1'b1);
    @(posedge clk); #1;

    // Give every pool word a defined value.
    for (int k = 0; k < 10; k++) do_write(pool_addr(k), $urandom, 32'hFFFF_FFFF, 1'b0, "init");

    do_write(Base, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, "wr idx0");
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, "wr word");
    do_read(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, "rd word");

    // Store byte at offset 3 over the previous word.
    do_write(32'h8000_0013, 32'h0000_0055, 32'h0000_00FF, 1'b0, "sb");
    do_read(32'h8000_0013, 32'h0000_0055, 1'b0, "lb off3");
    do_read(32'h8000_0010, 32'h55AD_BEEF, 1'b0, "rd merged");
    do_read(32'h8000_0012, 32'h0000_55AD, 1'b0, "rd off2");

    // Out-of-range accesses.
    do_read(32'h7FFF_FFFC, 32'h0, 1'b1, "rd below base");
    do_write(Base + 4 * Depth, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, "wr past end");
    do_read(Base, 32'hCAFE_F00D, 1'b0, "idx0 unchanged");

    // Back-pressure on R with a second AR already pending.
    do_ar(32'h8000_0010);
    bus.arvalid = 1'b1; bus.araddr = Base;
    wait_r(32'h55AD_BEEF, 1'b0, 1 + RdLat, 5, "stall");
    do_ar(Base);
    wait_r(32'hCAFE_F00D, 1'b0, 1 + RdLat, 0, "after stall");

    // Read sample and write commit on the same edge: read returns the old word.
    do_write(32'h8000_0018, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "wr old");
    do_aw(32'h8000_0018);
    bus.wdata = 32'h0000_0002; bus.wstrb = 32'hFFFF_FFFF;
    do_ar(32'h8000_0018);
    repeat (RdLat) @(posedge clk);
    #1 bus.wvalid = 1'b1;
    @(posedge clk); #1 bus.wvalid = 1'b0;
    wait_r(32'h0000_0001, 1'b0, -1, 0, "same-edge rd");
    wait_b(1'b0, "same-edge wr");
    do_read(32'h8000_0018, 32'h0000_0002, 1'b0, "reread new");

    // Random traffic against the model, with one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      bus.arvalid = 1'($urandom_range(0, 1));
      bus.araddr  = pick_addr();
      bus.rready  = 1'($urandom_range(0, 1));
      bus.awvalid = 1'($urandom_range(0, 1));
      bus.awaddr  = pick_addr();
      bus.wvalid  = 1'($urandom_range(0, 1));
      bus.wdata   = $urandom;
      bus.wstrb   = pick_strb();
      bus.bready  = 1'($urandom_range(0, 1));
      if (c == 1500) rst = 1'b0;
      if (c == 1503) rst = 1'b1;
      @(posedge clk); #1;
    end
    bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
    bus.rready = 1; bus.bready = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
